// File: rtl/aes_decipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the 128-bit state register and round counter,
// steps the round-key index NR..0 and presents the plaintext on a valid/ready handshake.
module aes_decipher_ctrl #(
    parameter  int NR = 10,
    localparam int CW = $clog2(NR + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [127:0]  i_in_data,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic          i_abort,
    output logic [CW-1:0] o_rk_idx,
    input  logic [127:0]  i_rk,
    output logic [127:0]  o_rnd_state,
    input  logic [127:0]  i_rnd_result,
    input  logic [127:0]  i_last_result,
    output logic [127:0]  o_out_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_busy
);
    // state | meaning
    // IDLE  | waiting for a ciphertext block, key index parked at NR
    // ROUND | inverse rounds NR-1..1, key index follows the counter
    // LAST  | final inverse round (no InvMixColumns) with key 0
    // DONE  | plaintext held on the output until downstream takes it
    typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_t;

    localparam logic [CW-1:0] NR_IDX = CW'(NR);
    localparam logic [CW-1:0] NR_M1  = CW'(NR - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t        r_state;
    state_t        w_next;
    logic [127:0]  r_state_reg;
    logic [CW-1:0] r_cnt;

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        o_rk_idx    = '0;
        case (r_state)
            IDLE: begin
                o_in_ready = !i_abort;
                o_rk_idx   = NR_IDX;
                if (i_in_valid) w_next = (NR > 1) ? ROUND : LAST;
            end
            ROUND: begin
                o_busy   = 1'b1;
                o_rk_idx = r_cnt;
                if (r_cnt == ONE) w_next = LAST;
            end
            LAST: begin
                o_busy = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // abort wins over both the input accept and the output handshake
        if (i_abort) w_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_state_reg <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            if (i_abort) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_in_valid) begin
                            r_state_reg <= i_in_data ^ i_rk;
                            r_cnt       <= NR_M1;
                        end
                    end
                    ROUND: begin
                        r_state_reg <= i_rnd_result;
                        r_cnt       <= r_cnt - ONE;
                    end
                    LAST:    r_state_reg <= i_last_result;
                    DONE:    if (i_out_ready) r_cnt <= '0;
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    assign o_rnd_state = r_state_reg;
    assign o_out_data  = r_state_reg;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl: two instances (AES-128 and AES-256 round counts) driven through a
// behavioural AES inverse-round datapath, checked against FIPS-197 vectors and a software decrypt.
module tb_aes_decipher_ctrl;
    localparam int NRA = 10;
    localparam int NRB = 14;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [127:0] a_in_data, a_rk, a_rnd_state, a_rnd_result, a_last_result, a_out_data;
    logic         a_in_valid, a_in_ready, a_abort, a_out_valid, a_out_ready, a_busy;
    logic [3:0]   a_rk_idx;
    logic [127:0] b_in_data, b_rk, b_rnd_state, b_rnd_result, b_last_result, b_out_data;
    logic         b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready, b_busy;
    logic [3:0]   b_rk_idx;
    logic [127:0] tab_a [0:15];
    logic [127:0] tab_b [0:15];

    aes_decipher_ctrl #(.NR(NRA)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_in_data(a_in_data), .i_in_valid(a_in_valid),
        .o_in_ready(a_in_ready), .i_abort(a_abort), .o_rk_idx(a_rk_idx), .i_rk(a_rk),
        .o_rnd_state(a_rnd_state), .i_rnd_result(a_rnd_result), .i_last_result(a_last_result),
        .o_out_data(a_out_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_busy(a_busy)
    );
    aes_decipher_ctrl #(.NR(NRB)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_in_data(b_in_data), .i_in_valid(b_in_valid),
        .o_in_ready(b_in_ready), .i_abort(b_abort), .o_rk_idx(b_rk_idx), .i_rk(b_rk),
        .o_rnd_state(b_rnd_state), .i_rnd_result(b_rnd_result), .i_last_result(b_last_result),
        .o_out_data(b_out_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_busy(b_busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] t, r;
        t = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_core(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k);
        return inv_mix(inv_core(s) ^ k);
    endfunction

    function automatic logic [127:0] inv_last(input logic [127:0] s, input logic [127:0] k);
        return inv_core(s) ^ k;
    endfunction

    // External round logic and combinational key store seen by each instance
    assign a_rk          = tab_a[a_rk_idx];
    assign a_rnd_result  = inv_round(a_rnd_state, a_rk);
    assign a_last_result = inv_last(a_rnd_state, a_rk);
    assign b_rk          = tab_b[b_rk_idx];
    assign b_rnd_result  = inv_round(b_rnd_state, b_rk);
    assign b_last_result = inv_last(b_rnd_state, b_rk);

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input int sel);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (sel == 0) tab_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else          tab_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // Reference: full inverse cipher in one software loop
    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input int nr);
        logic [127:0] s;
        s = ct ^ ((nr == NRA) ? tab_a[nr] : tab_b[nr]);
        for (int r = nr - 1; r >= 1; r--) s = inv_round(s, (nr == NRA) ? tab_a[r] : tab_b[r]);
        return inv_last(s, (nr == NRA) ? tab_a[0] : tab_b[0]);
    endfunction

    // Stimulus only: send one block to instance A with out_ready=1 and capture the result
    task automatic run_block_a(input logic [127:0] ct, output logic [127:0] got, output int lat);
        int k0;
        lat = -1;
        got = '0;
        k0  = -1;
        @(negedge clk); a_in_data = ct; a_in_valid = 1'b1; a_out_ready = 1'b1; #1;
        for (int i = 0; i < 40; i++) begin
            if (a_in_ready) begin k0 = i; break; end
            @(negedge clk); #1;
        end
        if (k0 < 0) begin a_in_valid = 1'b0; return; end
        for (int j = 1; j < 40; j++) begin
            @(negedge clk); a_in_valid = 1'b0; #1;
            if (a_out_valid) begin lat = j - 1; got = a_out_data; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_abort = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", a_out_valid); else pass_cnt++;
        chk_cnt++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", a_in_ready); else pass_cnt++;
        chk_cnt++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", a_busy); else pass_cnt++;
        chk_cnt++; if (a_rk_idx !== 4'(NRA)) $display("FAIL reset_rk_idx_a got %0d exp %0d", a_rk_idx, NRA); else pass_cnt++;
        chk_cnt++; if (a_out_data !== 128'h0) $display("FAIL reset_out_data got %h exp 0", a_out_data); else pass_cnt++;
        chk_cnt++; if (b_rk_idx !== 4'(NRB)) $display("FAIL reset_rk_idx_b got %0d exp %0d", b_rk_idx, NRB); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_fips128();
        @(negedge clk); a_in_data = CT128; a_in_valid = 1'b1; a_out_ready = 1'b1; #1;
        for (int k = 0; k <= NRA + 1; k++) begin
            if (k > 0) begin @(negedge clk); a_in_valid = 1'b0; #1; end
            if (k <= NRA) begin
                chk_cnt++; if (a_rk_idx !== 4'(NRA - k)) $display("FAIL fips128_rk_idx k=%0d got %0d exp %0d", k, a_rk_idx, NRA - k); else pass_cnt++;
            end
            chk_cnt++; if (a_busy !== (k >= 1 && k <= NRA)) $display("FAIL fips128_busy k=%0d got %b", k, a_busy); else pass_cnt++;
            chk_cnt++; if (a_out_valid !== (k == NRA + 1)) $display("FAIL fips128_out_valid k=%0d got %b", k, a_out_valid); else pass_cnt++;
        end
        chk_cnt++; if (a_out_data !== PT) $display("FAIL fips128_plaintext got %h exp %h", a_out_data, PT); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL fips128_return_idle got valid=%b ready=%b exp 0/1", a_out_valid, a_in_ready); else pass_cnt++;
    endtask

    task automatic test_fips256();
        @(negedge clk); b_in_data = CT256; b_in_valid = 1'b1; b_out_ready = 1'b1; #1;
        for (int k = 0; k <= NRB + 1; k++) begin
            if (k > 0) begin @(negedge clk); b_in_valid = 1'b0; #1; end
            if (k <= NRB) begin
                chk_cnt++; if (b_rk_idx !== 4'(NRB - k)) $display("FAIL fips256_rk_idx k=%0d got %0d exp %0d", k, b_rk_idx, NRB - k); else pass_cnt++;
            end
            chk_cnt++; if (b_out_valid !== (k == NRB + 1)) $display("FAIL fips256_out_valid k=%0d got %b", k, b_out_valid); else pass_cnt++;
        end
        chk_cnt++; if (b_out_data !== PT) $display("FAIL fips256_plaintext got %h exp %h", b_out_data, PT); else pass_cnt++;
        @(negedge clk); b_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] ct2;
        logic [3:0]   rk_hold;
        int           seen;
        ct2 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk); a_in_data = CT128; a_in_valid = 1'b1; a_out_ready = 1'b0; #1;
        @(negedge clk); a_in_data = ct2; #1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_out_valid) begin seen = 1; break; end
            @(negedge clk); #1;
        end
        chk_cnt++; if (seen != 1) $display("FAIL bp_timeout got no out_valid exp out_valid within 40 cycles"); else pass_cnt++;
        chk_cnt++; if (a_out_data !== PT) $display("FAIL bp_plaintext got %h exp %h", a_out_data, PT); else pass_cnt++;
        rk_hold = a_rk_idx;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk); #1;
            chk_cnt++;
            if (a_out_valid !== 1'b1 || a_out_data !== PT || a_in_ready !== 1'b0 || a_busy !== 1'b0 || a_rk_idx !== rk_hold)
                $display("FAIL bp_stall h=%0d got valid=%b data=%h ready=%b busy=%b rk=%0d exp 1/%h/0/0/%0d", h, a_out_valid, a_out_data, a_in_ready, a_busy, a_rk_idx, PT, rk_hold);
            else pass_cnt++;
        end
        @(negedge clk); a_out_ready = 1'b1; #1;
        chk_cnt++; if (a_in_ready !== 1'b0) $display("FAIL bp_handshake_ready got %b exp 0", a_in_ready); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_rk_idx !== 4'(NRA)) $display("FAIL bp_next_accept got valid=%b ready=%b rk=%0d exp 0/1/%0d", a_out_valid, a_in_ready, a_rk_idx, NRA); else pass_cnt++;
        @(negedge clk); a_in_valid = 1'b0; #1;
        chk_cnt++; if (a_busy !== 1'b1) $display("FAIL bp_accepted_busy got %b exp 1", a_busy); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_out_valid) begin seen = 1; break; end
            @(negedge clk); #1;
        end
        chk_cnt++; if (seen != 1 || a_out_data !== aes_dec(ct2, NRA)) $display("FAIL bp_second_block got %h exp %h", a_out_data, aes_dec(ct2, NRA)); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [127:0] got;
        int           lat;
        int           found;
        found = 0;
        @(negedge clk); a_in_data = CT128; a_in_valid = 1'b1; a_out_ready = 1'b1; #1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); a_in_valid = 1'b0; #1;
            if (a_busy && a_rk_idx == 4'd5) begin found = 1; break; end
        end
        chk_cnt++; if (found != 1) $display("FAIL arst_reach_idx5 got none exp rk_idx 5 while busy"); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        chk_cnt++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_rk_idx !== 4'(NRA)) $display("FAIL arst_immediate got valid=%b ready=%b busy=%b rk=%0d exp 0/1/0/%0d", a_out_valid, a_in_ready, a_busy, a_rk_idx, NRA); else pass_cnt++;
        #1 rst = 1'b0;
        run_block_a(CT128, got, lat);
        chk_cnt++; if (got !== PT) $display("FAIL arst_resend_data got %h exp %h", got, PT); else pass_cnt++;
        chk_cnt++; if (lat != NRA) $display("FAIL arst_resend_latency got %0d exp %0d", lat, NRA); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [127:0] got;
        int           lat, found, stray;
        found = 0;
        @(negedge clk); a_in_data = CT128; a_in_valid = 1'b1; a_out_ready = 1'b1; #1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); a_in_valid = 1'b0; #1;
            if (a_busy && a_rk_idx == 4'd3) begin found = 1; break; end
        end
        chk_cnt++; if (found != 1) $display("FAIL abort_reach_idx3 got none exp rk_idx 3 while busy"); else pass_cnt++;
        a_abort = 1'b1; a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom, $urandom}; #1;
        chk_cnt++; if (a_in_ready !== 1'b0) $display("FAIL abort_busy_ready got %b exp 0", a_in_ready); else pass_cnt++;
        @(negedge clk); a_abort = 1'b0; a_in_valid = 1'b0; #1;
        chk_cnt++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_rk_idx !== 4'(NRA)) $display("FAIL abort_to_idle got busy=%b valid=%b ready=%b rk=%0d exp 0/0/1/%0d", a_busy, a_out_valid, a_in_ready, a_rk_idx, NRA); else pass_cnt++;
        stray = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); #1; if (a_out_valid || a_busy) stray++; end
        chk_cnt++; if (stray != 0) $display("FAIL abort_no_output got %0d active cycles exp 0", stray); else pass_cnt++;
        run_block_a(CT128, got, lat);
        chk_cnt++; if (got !== PT || lat != NRA) $display("FAIL abort_resend got %h lat %0d exp %h lat %0d", got, lat, PT, NRA); else pass_cnt++;
        // abort in IDLE with a valid block: no accept
        @(negedge clk); a_abort = 1'b1; a_in_valid = 1'b1; a_in_data = CT128; #1;
        chk_cnt++; if (a_in_ready !== 1'b0) $display("FAIL abort_idle_ready got %b exp 0", a_in_ready); else pass_cnt++;
        @(negedge clk); a_abort = 1'b0; a_in_valid = 1'b0; #1;
        chk_cnt++; if (a_busy !== 1'b0) $display("FAIL abort_idle_no_accept got busy=%b exp 0", a_busy); else pass_cnt++;
        // abort in DONE together with out_ready
        @(negedge clk); a_in_data = CT128; a_in_valid = 1'b1; a_out_ready = 1'b0; #1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); a_in_valid = 1'b0; #1;
            if (a_out_valid) begin found = 1; break; end
        end
        a_abort = 1'b1; a_out_ready = 1'b1;
        @(negedge clk); a_abort = 1'b0; a_out_ready = 1'b0; #1;
        chk_cnt++; if (found != 1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL abort_done got found=%0d valid=%b ready=%b exp 1/0/1", found, a_out_valid, a_in_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        int acc_cyc[$];
        int sent, recv;
        sent = 0; recv = 0;
        @(negedge clk);
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom, $urandom}; #1;
        for (int cyc = 0; cyc < 200 && recv < 4; cyc++) begin
            if (cyc > 0) begin @(negedge clk); #1; end
            if (a_out_valid && a_out_ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL b2b_unexpected_output got %h exp none", a_out_data);
                else if (a_out_data !== exp_q[0]) $display("FAIL b2b_data got %h exp %h", a_out_data, exp_q[0]);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(aes_dec(a_in_data, NRA));
                acc_cyc.push_back(cyc);
                sent++;
                @(negedge clk);
                a_in_data = {$urandom, $urandom, $urandom, $urandom};
                a_in_valid = (sent < 4);
                #1;
                cyc++;
                if (a_out_valid) recv = recv;
            end
        end
        chk_cnt++; if (recv != 4) $display("FAIL b2b_count got %0d exp 4", recv); else pass_cnt++;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk_cnt++; if (acc_cyc[i] - acc_cyc[i-1] != NRA + 2) $display("FAIL b2b_interval i=%0d got %0d exp %0d", i, acc_cyc[i] - acc_cyc[i-1], NRA + 2); else pass_cnt++;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] exp_q[$];
        int sent, recv;
        logic accepted;
        sent = 0; recv = 0; accepted = 1'b0;
        for (int cyc = 0; cyc < 800 && recv < 10; cyc++) begin
            @(negedge clk);
            if (accepted) a_in_valid = 1'b0;
            if (!a_in_valid && sent < 10 && $urandom_range(0, 2) != 0) begin
                a_in_data  = {$urandom, $urandom, $urandom, $urandom};
                a_in_valid = 1'b1;
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            accepted = 1'b0;
            if (a_out_valid && a_out_ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL rand_unexpected_output got %h exp none", a_out_data);
                else if (a_out_data !== exp_q[0]) $display("FAIL rand_data got %h exp %h", a_out_data, exp_q[0]);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(aes_dec(a_in_data, NRA));
                sent++;
                accepted = 1'b1;
            end
        end
        chk_cnt++; if (recv != 10) $display("FAIL rand_count got %0d exp 10", recv); else pass_cnt++;
        @(negedge clk); a_in_valid = 1'b0; a_out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin tab_a[i] = '0; tab_b[i] = '0; end
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NRA, 0);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NRB, 1);
        test_reset();
        test_fips128();
        test_fips256();
        test_backpressure();
        test_async_reset();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
